reg_file_bypass: RTL and testbench

REG_FILE_BYPASS -- requirements
Module: reg_file_bypass

---
 rtl/reg_file_bypass.sv | 77 +++++++
 tb/tb_reg_file_bypass.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_bypass.sv
// rtl/reg_file_bypass.sv - 31x32 register file with x0 hardwired to zero, write-to-read bypass and write counter
module reg_file_bypass #(
    parameter int unsigned BYPASS_EN = 1,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rstN,
    input  logic        i_rdWren,
    input  logic [4:0]  i_rdAddr,
    input  logic [31:0] i_rdData,
    input  logic [4:0]  i_rs1Addr,
    input  logic [4:0]  i_rs2Addr,
    input  logic [4:0]  i_dbgAddr,
    output logic [31:0] o_rs1Data,
    output logic [31:0] o_rs2Data,
    output logic [31:0] o_dbgData,
    output logic [15:0] o_wrCount
);

    logic [31:0] regs [1:31];
    logic [31:0] view [32];
    logic [31:1] wr_strobe;
    logic        commit;
    logic        bypass_rs1;
    logic        bypass_rs2;
    logic [15:0] wr_count;

    // One-hot decode of the destination; x0 has no strobe so its writes vanish.
    always_comb begin
        wr_strobe = '0;
        for (int i = 1; i < 32; i++) begin
            wr_strobe[i] = i_rdWren && (i_rdAddr == 5'(i));
        end
    end

    assign commit = |wr_strobe;

    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wr_strobe[i]) begin
                    regs[i] <= i_rdData;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            wr_count <= '0;
        end else if (commit && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
        end
    end

    // Full 32-entry view so every read address is in range; entry 0 is constant zero.
    always_comb begin
        view[0] = '0;
        for (int i = 1; i < 32; i++) begin
            view[i] = regs[i];
        end
    end

    // Bypass ignores reset on purpose: the path stays live while writes are blocked.
    assign bypass_rs1 = (BYPASS_EN != 0) && commit && (i_rs1Addr == i_rdAddr);
    assign bypass_rs2 = (BYPASS_EN != 0) && commit && (i_rs2Addr == i_rdAddr);

    assign o_rs1Data = bypass_rs1 ? i_rdData : view[i_rs1Addr];
    assign o_rs2Data = bypass_rs2 ? i_rdData : view[i_rs2Addr];
    assign o_dbgData = view[i_dbgAddr];
    assign o_wrCount = wr_count;

endmodule

// File: tb/tb_reg_file_bypass.sv
// tb/tb_reg_file_bypass.sv - directed self-checking bench for reg_file_bypass with and without bypass
module tb_reg_file_bypass;

    logic        clk;
    logic        rst_n;
    logic        wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  dbg_addr;
    logic [31:0] rs1_a, rs2_a, dbg_a;
    logic [15:0] cnt_a;
    logic [31:0] rs1_b, rs2_b, dbg_b;
    logic [15:0] cnt_b;

    int checks = 0;
    int errors = 0;

    reg_file_bypass #(.BYPASS_EN(1)) u_dut (
        .i_clk(clk), .i_rstN(rst_n), .i_rdWren(wren), .i_rdAddr(rd_addr),
        .i_rdData(rd_data), .i_rs1Addr(rs1_addr), .i_rs2Addr(rs2_addr),
        .i_dbgAddr(dbg_addr), .o_rs1Data(rs1_a), .o_rs2Data(rs2_a),
        .o_dbgData(dbg_a), .o_wrCount(cnt_a)
    );

    reg_file_bypass #(.BYPASS_EN(0)) u_dut_nb (
        .i_clk(clk), .i_rstN(rst_n), .i_rdWren(wren), .i_rdAddr(rd_addr),
        .i_rdData(rd_data), .i_rs1Addr(rs1_addr), .i_rs2Addr(rs2_addr),
        .i_dbgAddr(dbg_addr), .o_rs1Data(rs1_b), .o_rs2Data(rs2_b),
        .o_dbgData(dbg_b), .o_wrCount(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic set_read(input logic [4:0] a);
        rs1_addr = a;
        rs2_addr = a;
        dbg_addr = a;
    endtask

    task automatic do_reset();
        @(negedge clk);
        wren  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_v;
        rst_n = 1'b1;
        wren = 1'b0;
        rd_addr = '0;
        rd_data = '0;
        set_read(5'd0);

        // Reset state on every address
        do_reset();
        for (int a = 0; a < 32; a++) begin
            set_read(5'(a));
            #1;
            check($sformatf("rst_rs1_%0d", a), rs1_a, 32'h0);
            check($sformatf("rst_rs2_%0d", a), rs2_a, 32'h0);
            check($sformatf("rst_dbg_%0d", a), dbg_a, 32'h0);
        end
        check("rst_cnt", {16'h0, cnt_a}, 32'h0);

        // Basic write then read next cycle
        @(negedge clk);
        wren = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEAD_BEEF;
        @(negedge clk);
        wren = 1'b0; rs1_addr = 5'd5;
        #1;
        check("basic_rs1", rs1_a, 32'hDEAD_BEEF);
        check("basic_cnt", {16'h0, cnt_a}, 32'd1);
        check("basic_nb_rs1", rs1_b, 32'hDEAD_BEEF);

        // Write to x0 is discarded and never bypassed
        @(negedge clk);
        wren = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFF_FFFF; rs1_addr = 5'd0;
        #1;
        check("x0_same_rs1", rs1_a, 32'h0);
        @(negedge clk);
        wren = 1'b0;
        #1;
        check("x0_next_rs1", rs1_a, 32'h0);
        check("x0_cnt", {16'h0, cnt_a}, 32'd1);

        // Bypass on both ports; debug and non-bypass instance see the stored value
        @(negedge clk);
        wren = 1'b1; rd_addr = 5'd7; rd_data = 32'h1111_1111;
        @(negedge clk);
        rd_data = 32'h2222_2222; set_read(5'd7);
        #1;
        check("byp_rs1", rs1_a, 32'h2222_2222);
        check("byp_rs2", rs2_a, 32'h2222_2222);
        check("byp_dbg", dbg_a, 32'h1111_1111);
        check("nb_rs1", rs1_b, 32'h1111_1111);
        check("nb_rs2", rs2_b, 32'h1111_1111);
        @(negedge clk);
        wren = 1'b1; rd_addr = 5'd5; rd_data = 32'h5555_0000;
        rs1_addr = 5'd7; rs2_addr = 5'd5;
        #1;
        check("nb_after_commit", rs1_b, 32'h2222_2222);
        check("mix_rs1_stored", rs1_a, 32'h2222_2222);
        check("mix_rs2_byp", rs2_a, 32'h5555_0000);
        check("mix_nb_rs2", rs2_b, 32'hDEAD_BEEF);
        @(negedge clk);
        wren = 1'b0;
        #1;
        check("mix_cnt", {16'h0, cnt_a}, 32'd4);

        // Full sweep after a fresh reset
        do_reset();
        for (int i = 1; i < 32; i++) begin
            wren = 1'b1; rd_addr = 5'(i); rd_data = 32'(i) * 32'h0101_0101;
            @(negedge clk);
        end
        wren = 1'b0;
        for (int a = 0; a < 32; a++) begin
            set_read(5'(a));
            #1;
            exp_v = 32'(a) * 32'h0101_0101;
            check($sformatf("sweep_rs1_%0d", a), rs1_a, exp_v);
            check($sformatf("sweep_rs2_%0d", a), rs2_a, exp_v);
            check($sformatf("sweep_dbg_%0d", a), dbg_a, exp_v);
        end
        check("sweep_cnt", {16'h0, cnt_a}, 32'd31);

        // Reset dropped mid write cycle wins over the write
        @(negedge clk);
        wren = 1'b1; rd_addr = 5'd3; rd_data = 32'hA5A5_A5A5; set_read(5'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_dbg", dbg_a, 32'h0);
        check("mid_nb_rs1", rs1_b, 32'h0);
        check("mid_byp_rs1", rs1_a, 32'hA5A5_A5A5);
        check("mid_cnt", {16'h0, cnt_a}, 32'h0);
        @(negedge clk);
        wren = 1'b0;
        rst_n = 1'b1;
        #1;
        check("post_dbg", dbg_a, 32'h0);
        check("post_cnt", {16'h0, cnt_a}, 32'h0);

        // First edge after release commits normally
        wren = 1'b1; rd_addr = 5'd9; rd_data = 32'h0BAD_F00D;
        @(negedge clk);
        wren = 1'b0; set_read(5'd9);
        #1;
        check("rel_dbg", dbg_a, 32'h0BAD_F00D);
        check("rel_cnt", {16'h0, cnt_a}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
